sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_pkg.sv | 14 +
 rtl/sram_arb_grant.sv | 57 +++++
 rtl/sram_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared widths, requester count and state encoding for the SRAM arbiter
package sram_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 32;
  localparam int NUM_REQ    = 2;

  // SERVE: requesters own the SRAM port; CLEAR: zero-fill sweep owns it.
  typedef enum logic {
    ST_SERVE = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/sram_arb_grant.sv
// rtl/sram_arb_grant.sv - one-hot grant between two requesters; round-robin when ARB_RR_EN is defined, fixed priority otherwise
import sram_pkg::*;

module sram_arb_grant (
`ifdef ARB_RR_EN
  input  logic               clk_i,
  input  logic               reset_i,
`endif
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_valid_i,
  output logic [NUM_REQ-1:0] grant_o
);

`ifdef ARB_RR_EN
  // prio_q names the requester that wins the next conflict.
  logic prio_q;
  logic prio_d;

  // Conflicts go to the requester that was not served last; the pointer only moves on a transfer.
  always_comb begin
    grant_o = '0;
    prio_d  = prio_q;
    if (en_i) begin
      if (req_valid_i == 2'b11) begin
        grant_o = prio_q ? 2'b10 : 2'b01;
      end else begin
        grant_o = req_valid_i;
      end
    end
    if (grant_o != '0) begin
      prio_d = grant_o[0];
    end
  end

  // Priority pointer register; requester 0 is favoured out of reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  // Requester 0 always wins a conflict; requester 1 is served only when 0 is idle.
  always_comb begin
    grant_o = '0;
    if (en_i) begin
      if (req_valid_i[0]) begin
        grant_o = 2'b01;
      end else begin
        grant_o = req_valid_i;
      end
    end
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-requester single-port SRAM arbiter with zero-fill sweep; ARB_RR_EN selects round-robin grant
import sram_pkg::*;

module sram_arbiter #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr_start,
  output logic                      clr_busy,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      sram_cen,
  output logic                      sram_wen,
  output logic [ADDR_W-1:0]         sram_a,
  output logic [DATA_W-1:0]         sram_d,
  input  logic [DATA_W-1:0]         sram_q
);

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [NUM_REQ-1:0]  rsp_valid_d;
  logic [NUM_REQ-1:0]  grant;
  logic                serve_en;
  logic                clear_wr;
  logic                gsel;

  // Grants are suppressed while reset is held so nothing reaches the SRAM during reset.
  assign serve_en = !reset && (state_q == ST_SERVE);
  assign clear_wr = !reset && (state_q == ST_CLEAR);
  assign gsel     = grant[1];

  sram_arb_grant u_grant (
`ifdef ARB_RR_EN
    .clk_i       (clk),
    .reset_i     (reset),
`endif
    .en_i        (serve_en),
    .req_valid_i (req_valid),
    .grant_o     (grant)
  );

  assign req_ready = grant;
  assign clr_busy  = (state_q == ST_CLEAR);
  assign rsp_valid = rsp_valid_q;
  // The SRAM returns read data the cycle after the access, which is when rsp_valid is high.
  assign rsp_data  = sram_q;

  // SRAM port mux: granted requester in SERVE, sweep counter writing zeros in CLEAR, idle otherwise.
  always_comb begin
    sram_cen = 1'b1;
    sram_wen = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    if (grant != '0) begin
      sram_cen = 1'b0;
      sram_wen = ~req_we[gsel];
      sram_a   = gsel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
      sram_d   = gsel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    end else if (clear_wr) begin
      sram_cen = 1'b0;
      sram_wen = 1'b0;
      sram_a   = clr_cnt_q;
      sram_d   = '0;
    end
  end

  // A read transfer this cycle owes its requester a response strobe next cycle.
  always_comb begin
    rsp_valid_d = grant & ~req_we;
  end

  // Sequencer: SERVE/CLEAR state, sweep address counter and response strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SERVE;
      clr_cnt_q   <= '0;
      rsp_valid_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      case (state_q)
        ST_SERVE: begin
          if (clr_start) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
          end
        end
        ST_CLEAR: begin
          // clr_start is ignored here; the sweep always runs to the top address.
          if (clr_cnt_q == {ADDR_W{1'b1}}) begin
            state_q <= ST_SERVE;
          end
          clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
        end
        default: begin
          state_q <= ST_SERVE;
        end
      endcase
    end
  end

endmodule
